clk_period_meter: RTL and testbench

- Measuring end of the slow-clock path.
- Takes an external or divided square wave (e.g. the 400 Hz display strobe), synchronises it to clk_in, and measures its period and high time in clk_in cycles.
- Used for self-check of divider outputs and for external signal frequency readout on the seven-segment display.

---
 rtl/clk_meas_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 33 +++
 rtl/clk_period_meter.sv | 175 +++++++++++++++++
 tb/tb_clk_period_meter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEAS_HIGH,
    MEAS_LOW
  } meas_state_t;

  localparam int CNT_W_DEFAULT   = 24;
  localparam int TIMEOUT_DEFAULT = 10_000_000;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser for an asynchronous input followed by a one-flop
// edge detector producing single-cycle rise/fall pulses.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic reset,
  input  logic async_in,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes the shift chain work.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign sync_o = r_sync[SYNC_STAGES-1];
  assign rise_o = sync_o & ~r_prev;
  assign fall_o = ~sync_o & r_prev;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a synchronised square wave in clk_in cycles.
// Optional: define CLK_PERIOD_METER_AVG_EN to report the average of 4 results.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic w_sync, w_rise, w_fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in   (clk_in),
    .reset    (reset),
    .async_in (sig_in),
    .sync_o   (w_sync),
    .rise_o   (w_rise),
    .fall_o   (w_fall)
  );

  meas_state_t      r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt, r_hi_cnt, w_hi_cnt;
  logic [CNT_W-1:0] r_period, w_period, r_high, w_high;
  logic             r_valid, w_valid, r_timeout, w_timeout;
  logic             w_done, w_to_hit;
  logic [CNT_W-1:0] w_meas_p, w_meas_h;

`ifdef CLK_PERIOD_METER_AVG_EN
  logic [CNT_W+1:0] r_acc_p, w_acc_p, r_acc_h, w_acc_h, w_sum_p, w_sum_h;
  logic [1:0]       r_nsamp, w_nsamp;
`endif

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_hi_cnt = r_hi_cnt;
    w_done   = 1'b0;
    w_to_hit = 1'b0;
    w_meas_p = '0;
    w_meas_h = '0;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (w_rise) begin
          w_cnt   = CNT_ONE;
          w_state = MEAS_HIGH;
        end
      end
      MEAS_HIGH, MEAS_LOW: begin
        if (w_rise) begin
          // A rise while still high means the fall was missed: report 100% duty.
          w_done   = 1'b1;
          w_meas_p = r_cnt;
          w_meas_h = (r_state == MEAS_HIGH) ? r_cnt : r_hi_cnt;
          w_cnt    = CNT_ONE;
          w_state  = MEAS_HIGH;
        end else if (r_cnt == TIMEOUT_V) begin
          w_to_hit = 1'b1;
          w_cnt    = '0;
          w_state  = IDLE;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
          if (r_state == MEAS_HIGH && w_fall) begin
            w_hi_cnt = r_cnt;
            w_state  = MEAS_LOW;
          end
        end
      end
      default: begin
        w_cnt   = '0;
        w_state = IDLE;
      end
    endcase
  end

  always_comb begin
    w_period  = r_period;
    w_high    = r_high;
    w_valid   = 1'b0;
    w_timeout = r_timeout;
`ifdef CLK_PERIOD_METER_AVG_EN
    w_acc_p = r_acc_p;
    w_acc_h = r_acc_h;
    w_nsamp = r_nsamp;
    w_sum_p = r_acc_p + {2'b00, w_meas_p};
    w_sum_h = r_acc_h + {2'b00, w_meas_h};
    if (w_to_hit) begin
      w_timeout = 1'b1;
      w_period  = '0;
      w_high    = '0;
      w_acc_p   = '0;
      w_acc_h   = '0;
      w_nsamp   = '0;
    end else if (w_done) begin
      w_timeout = 1'b0;
      if (r_nsamp == 2'd3) begin
        w_period = w_sum_p[CNT_W+1:2];
        w_high   = w_sum_h[CNT_W+1:2];
        w_valid  = 1'b1;
        w_acc_p  = '0;
        w_acc_h  = '0;
        w_nsamp  = '0;
      end else begin
        w_acc_p = w_sum_p;
        w_acc_h = w_sum_h;
        w_nsamp = r_nsamp + 2'd1;
      end
    end
`else
    if (w_to_hit) begin
      w_timeout = 1'b1;
      w_period  = '0;
      w_high    = '0;
    end else if (w_done) begin
      w_timeout = 1'b0;
      w_period  = w_meas_p;
      w_high    = w_meas_h;
      w_valid   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hi_cnt  <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
`ifdef CLK_PERIOD_METER_AVG_EN
      r_acc_p   <= '0;
      r_acc_h   <= '0;
      r_nsamp   <= '0;
`endif
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_hi_cnt  <= w_hi_cnt;
      r_period  <= w_period;
      r_high    <= w_high;
      r_valid   <= w_valid;
      r_timeout <= w_timeout;
`ifdef CLK_PERIOD_METER_AVG_EN
      r_acc_p   <= w_acc_p;
      r_acc_h   <= w_acc_h;
      r_nsamp   <= w_nsamp;
`endif
    end
  end

  // A rise pulse can only exist while the synchronised level is high.
  a_rise_implies_high: assert property (@(posedge clk_in) disable iff (!reset) w_rise |-> w_sync);

  assign period_o  = r_period;
  assign high_o    = r_high;
  assign valid_o   = r_valid;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomised bench for clk_period_meter against a rise-to-rise interval model.
module tb_clk_period_meter;

  localparam int CNT_W = 16;
  localparam int TO    = 2000;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period_o, high_o;
  logic             valid_o, timeout_o;

  clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO), .SYNC_STAGES(2)) dut (
    .clk_in    (clk),
    .reset     (rst_n),
    .sig_in    (sig_in),
    .period_o  (period_o),
    .high_o    (high_o),
    .valid_o   (valid_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: a result is the distance between consecutive driven
  // rises plus the preceding high length; a gap above TO is a loss of signal.
  typedef struct {
    int period;
    int high;
  } meas_t;

  meas_t exp_q[$];
  int    now        = 0;
  int    last_rise  = 0;
  int    last_high  = 0;
  bit    have_start = 1'b0;
  bit    level      = 1'b0;
  int    grp_n = 0, grp_p = 0, grp_h = 0;

  function automatic void model_clear();
    have_start = 1'b0;
    grp_n = 0; grp_p = 0; grp_h = 0;
  endfunction

  function automatic void model_result(int p, int h);
`ifdef CLK_PERIOD_METER_AVG_EN
    grp_p += p; grp_h += h; grp_n++;
    if (grp_n == 4) begin
      exp_q.push_back('{grp_p / 4, grp_h / 4});
      grp_n = 0; grp_p = 0; grp_h = 0;
    end
`else
    exp_q.push_back('{p, h});
`endif
  endfunction

  // Drive a level for n cycles; drives always land 1 time unit after posedge.
  task automatic phase(input bit v, input int n);
    if (v && !level) begin
      if (have_start && (now - last_rise) <= TO) model_result(now - last_rise, last_high);
      else model_clear();
      have_start = 1'b1;
      last_rise  = now;
    end else if (!v && level) begin
      last_high = now - last_rise;
    end
    level  = v;
    sig_in = v;
    repeat (n) @(posedge clk);
    #1;
    now += n;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("rst_async_period", period_o, 0);
    check("rst_async_high", high_o, 0);
    check("rst_async_valid", valid_o, 0);
    check("rst_async_timeout", timeout_o, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    now += 3;
    model_clear();
  endtask

  always @(negedge clk) begin
    meas_t e;
    if (rst_n && valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("period", period_o, e.period);
        check("high", high_o, e.high);
        check("timeout_on_valid", timeout_o, 0);
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_period", period_o, 0);
    check("reset_high", high_o, 0);
    check("reset_valid", valid_o, 0);
    check("reset_timeout", timeout_o, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 25% duty then 75% duty at a 1000-cycle period.
    repeat (3) begin phase(1'b1, 250); phase(1'b0, 750); end
    repeat (3) begin phase(1'b1, 750); phase(1'b0, 250); end

    repeat (30) begin
      phase(1'b1, int'($urandom_range(3, 500)));
      phase(1'b0, int'($urandom_range(3, 500)));
    end

    // Period exactly TO: the rise wins over timeout. Then TO+1: loss of signal.
    phase(1'b1, 500); phase(1'b0, 1500);
    phase(1'b1, 500); phase(1'b0, 1501);
    phase(1'b1, 100);
    check("timeout_at_to_plus_1", timeout_o, 1);
    phase(1'b0, 100);
    phase(1'b1, 200); phase(1'b0, 200);

    // Hold low: timeout_o must rise exactly TO+3 edges after the last driven rise.
    phase(1'b1, 200);
    last_high = now - last_rise;
    level  = 1'b0;
    sig_in = 1'b0;
    repeat (TO + 2 - 200) @(posedge clk);
    @(negedge clk);
    check("timeout_not_yet", timeout_o, 0);
    @(posedge clk);
    @(negedge clk);
    check("timeout_set", timeout_o, 1);
    check("timeout_period", period_o, 0);
    check("timeout_high", high_o, 0);
    repeat (20) @(posedge clk);
    #1;
    now += TO + 2 - 200 + 1 + 20;

    // Burst after timeout: first rise only restarts.
    phase(1'b1, 300);
    check("timeout_held_first_rise", timeout_o, 1);
    phase(1'b0, 300);
    phase(1'b1, 300); phase(1'b0, 300);
    phase(1'b1, 300); phase(1'b0, 100);

    // Reset in the middle of a low phase discards the partial measurement.
    reset_pulse();
    phase(1'b0, 200);
    phase(1'b1, 300); phase(1'b0, 300);
    phase(1'b1, 300); phase(1'b0, 300);

    // Averaging group: periods 1000, 1002, 1004, 1006 from a fresh start.
    reset_pulse();
    phase(1'b0, 20);
    phase(1'b1, 500); phase(1'b0, 500);
    phase(1'b1, 500); phase(1'b0, 502);
    phase(1'b1, 502); phase(1'b0, 502);
    phase(1'b1, 503); phase(1'b0, 503);
    phase(1'b1, 400); phase(1'b0, 100);

    check("all_results_seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
